pipeline_skid_buffer: RTL

Two-entry ready/valid pipeline stage that sits between a producer and a consumer. It fully decouples both handshakes: `input_ready` and `output_valid` are driven straight from flip-flops, so there is no combinational path from input to output or from `output_ready` to `input_ready`. It sustains one transfer per cycle and is built from two plain data registers (output and skid) plus a 3-state controller.

---
 rtl/pipeline_skid_buffer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pipeline_skid_buffer.sv
// Two-entry ready/valid stage with registered input_ready/output_valid (output + skid register).
// Define PIPELINE_SKID_BUFFER_CIRCULAR_EN to overwrite the oldest item instead of back-pressuring.
module pipeline_skid_buffer #(
    parameter int WORD_WIDTH = 0
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  input_valid,
    output logic                  input_ready,
    input  logic [WORD_WIDTH-1:0] input_data,
    output logic                  output_valid,
    input  logic                  output_ready,
    output logic [WORD_WIDTH-1:0] output_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [WORD_WIDTH-1:0] skid_data;
    logic                  insert;
    logic                  remove;
    logic                  next_input_ready;
    logic                  load_output_from_input;
    logic                  load_output_from_skid;
    logic                  load_skid;

    assign insert = input_valid & input_ready;
    assign remove = output_valid & output_ready;

    // Handshake outputs are flops loaded from the next state, keeping both sides decoupled.
    always_ff @(posedge clock) begin
        if (clear) begin
            state        <= EMPTY;
            output_valid <= 1'b0;
            input_ready  <= 1'b1;
        end else begin
            state        <= next_state;
            output_valid <= (next_state != EMPTY);
            input_ready  <= next_input_ready;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            EMPTY: begin
                if (insert) begin
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (insert && !remove) begin
                    next_state = FULL;
                end else if (!insert && remove) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
`ifdef PIPELINE_SKID_BUFFER_CIRCULAR_EN
                if (remove && !insert) begin
                    next_state = BUSY;
                end
`else
                if (remove) begin
                    next_state = BUSY;
                end
`endif
            end
            default: next_state = EMPTY;
        endcase
    end

`ifdef PIPELINE_SKID_BUFFER_CIRCULAR_EN
    assign next_input_ready = 1'b1;
`else
    assign next_input_ready = (next_state != FULL);
`endif

    always_comb begin
        load_output_from_input = 1'b0;
        load_output_from_skid  = 1'b0;
        load_skid              = 1'b0;
        case (state)
            EMPTY: begin
                load_output_from_input = insert;
            end
            BUSY: begin
                load_output_from_input = insert & remove;
                load_skid              = insert & ~remove;
            end
            FULL: begin
`ifdef PIPELINE_SKID_BUFFER_CIRCULAR_EN
                // A write into a full buffer shifts the pair along, dropping the oldest item.
                load_output_from_skid = remove | insert;
                load_skid             = insert;
`else
                load_output_from_skid = remove;
`endif
            end
            default: begin
                load_output_from_input = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            output_data <= '0;
            skid_data   <= '0;
        end else begin
            if (load_output_from_input) begin
                output_data <= input_data;
            end else if (load_output_from_skid) begin
                output_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= input_data;
            end
        end
    end

endmodule
